local_predictor: RTL and testbench



---
 rtl/local_predictor.sv | 49 ++++
 tb/tb_local_predictor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/local_predictor.sv
// Single-entry 2-bit saturating-counter branch-direction predictor.
// Trained from the Execute-stage outcome; prediction is the counter MSB.

module local_predictor #(
  parameter int                     COUNTER_WIDTH = 2,
  parameter logic [COUNTER_WIDTH-1:0] RESET_STATE = 2'b01
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pc_src_res_e_i,
  input  logic enable_i,
  output logic pc_src_pred_o
);

  typedef enum logic [COUNTER_WIDTH-1:0] {
    SU = 'd0,
    WU = 'd1,
    WT = 'd2,
    ST = 'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Saturating step: move one state toward the resolved direction, clamp at the ends.
  always_comb begin
    w_nextState = r_state;
    if (enable_i) begin
      unique case (r_state)
        SU:      w_nextState = pc_src_res_e_i ? WU : SU;
        WU:      w_nextState = pc_src_res_e_i ? WT : SU;
        WT:      w_nextState = pc_src_res_e_i ? ST : WU;
        ST:      w_nextState = pc_src_res_e_i ? ST : WT;
        default: w_nextState = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_nextState;
    end
  end

  assign pc_src_pred_o = r_state[COUNTER_WIDTH-1];

endmodule

// File: tb/tb_local_predictor.sv
// Scoreboard bench for local_predictor: directed vectors push hand-computed
// predictions into a queue, a negedge monitor pops and compares them.

module tb_local_predictor;

  logic clk = 1'b0;
  logic resetIn = 1'b1;
  logic resIn = 1'b0;
  logic enableIn = 1'b0;
  logic predOut;

  typedef struct {
    logic  exp;
    string tag;
  } expItem_t;

  expItem_t expQ[$];
  int errors = 0;
  int checks = 0;

  local_predictor #(
    .COUNTER_WIDTH(2),
    .RESET_STATE  (2'b01)
  ) dut (
    .clk_i         (clk),
    .reset_i       (resetIn),
    .pc_src_res_e_i(resIn),
    .enable_i      (enableIn),
    .pc_src_pred_o (predOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got pred=%b, expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one edge's worth of inputs, then queue the prediction expected after that edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic en,
                               input logic res, input logic exp);
    @(negedge clk);
    resetIn  = rst;
    enableIn = en;
    resIn    = res;
    @(posedge clk);
    expQ.push_back('{exp: exp, tag: tag});
  endtask

  // Monitor: the prediction is compared half a cycle after the edge that produced it.
  initial begin
    expItem_t item;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        item = expQ.pop_front();
        checkOutput(item.tag, predOut, item.exp);
      end
    end
  end

  initial begin
    logic [3:0] burstExp;
    logic       burstRes;

    // Reset init, then idle with enable low
    applyStimulus("reset0", 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("reset1", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("idleWU", 1'b0, 1'b0, 1'b1, 1'b0);

    // Taken training WU -> WT, ST, ST, ST
    for (int i = 0; i < 4; i++) applyStimulus("takenTrain", 1'b0, 1'b1, 1'b1, 1'b1);

    // Untaken training ST -> WT, WU, SU, SU
    applyStimulus("untaken0", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("untaken1", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("untaken2", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("untaken3", 1'b0, 1'b1, 1'b0, 1'b0);

    // Back to WU, then alternating 4-edge bursts starting with taken
    applyStimulus("resetWU", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      burstRes = (b % 2 == 0);
      if (b == 0)          burstExp = 4'b1111;
      else if (b % 2 == 1) burstExp = 4'b1000;
      else                 burstExp = 4'b0111;
      for (int i = 0; i < 4; i++)
        applyStimulus("altBurst", 1'b0, 1'b1, burstRes, burstExp[3-i]);
    end

    // From SU climb to ST, then hold with enable low
    applyStimulus("climb0", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("climb1", 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("climb2", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++)
      applyStimulus("holdST", 1'b0, 1'b0, logic'((i / 4) % 2), 1'b1);

    // Descend to SU, then hold with enable low
    applyStimulus("fall0", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("fall1", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("fall2", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++)
      applyStimulus("holdSU", 1'b0, 1'b0, logic'(((i / 4) + 1) % 2), 1'b0);

    // Reset priority while in ST with a taken update pending
    applyStimulus("toST0", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("toST1", 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("toST2", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus("resetPrio", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("postReset", 1'b0, 1'b1, 1'b1, 1'b1);

    // Mid-training reset from WT, then walk SU -> WU -> WT
    applyStimulus("midReset", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("wuToSU", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("suToWU", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("wuToWT", 1'b0, 1'b1, 1'b1, 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
